// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states
// and small op-code classification helpers.
package mips_muldiv_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add for
// multiply, restoring shift-subtract for divide, on the {acc_hi, acc_lo} pair.
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // Remainder is always below the divisor, so the difference fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            next_hi = fits ? diff : shifted[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], fits};
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on issue; signs are reapplied in FIX.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, operand;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               is_div, neg_q, neg_r, div_zero;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot, rem;

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        a_neg   = op_is_signed(op_code) & op_a[WIDTH-1];
        b_neg   = op_is_signed(op_code) & op_b[WIDTH-1];
        a_mag   = a_neg ? -op_a : op_a;
        b_mag   = b_neg ? -op_b : op_b;
        product = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        // Remainder of a divide by zero is |a|, so the sign fix restores op_a.
        quot    = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
        rem     = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (op_valid && !abort) begin
                        if (op_is_muldiv(op_code)) begin
                            state    <= MD_CALC;
                            busy     <= 1'b1;
                            count    <= '0;
                            is_div   <= op_is_div(op_code);
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= (op_b == '0);
                            acc_hi   <= '0;
                            acc_lo   <= op_is_div(op_code) ? a_mag : b_mag;
                            operand  <= op_is_div(op_code) ? b_mag : a_mag;
                        end else if (op_code == MD_OP_MTHI) begin
                            hi <= op_a;
                        end else if (op_code == MD_OP_MTLO) begin
                            lo <= op_a;
                        end
                    end
                end
                MD_CALC: begin
                    if (abort) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count + CW'(1);
                        if (count == CW'(WIDTH-1))
                            state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem;
                            lo <= quot;
                        end else begin
                            hi <= product[2*WIDTH-1:WIDTH];
                            lo <= product[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the simple MIPS core's execution stage.
- Sits directly downstream of operand read and consumes opA/opB plus a decoded op code.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and provides HI/LO to the writeback bus for MFHI/MFLO.
- The core stalls issue while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  issue strobe; accepted only when busy=0
- op_code  input  3  MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU, MD_OP_MTHI, MD_OP_MTLO
- op_a  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
- op_b  input  WIDTH  rt operand (multiplier / divisor)
- abort  input  1  flush; cancels an in-flight operation
- busy  output  1  high while a mul/div is in flight
- done  output  1  one-cycle pulse when HI/LO take a mul/div result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, iteration counter=0. Reset mid-operation discards the work.
- State machine IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - op_valid with a mul/div op: latch operand magnitudes (abs for signed ops), result signs and the op kind; clear the accumulator; counter=0; go to CALC. busy=1 from the next cycle.
  - op_valid with MTHI/MTLO: write op_a to hi or lo on that edge. No busy, no done.
  - Undefined op_code: ignored.
- CALC: one iteration per cycle for exactly WIDTH cycles; leaves to FIX on the edge where counter==WIDTH-1.
  - Multiply: radix-2 shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract, quotient and remainder WIDTH bits each.
- FIX: one cycle.
  - Apply sign: signed product negated if sign(a) xor sign(b); quotient negated likewise; remainder takes sign(a).
  - Write hi/lo on the edge leaving FIX. That same edge sets done=1 (for one cycle), sets busy=0 and returns to IDLE.
- Latency: issue at edge E0; hi/lo/done visible after edge E(WIDTH+1), i.e. E33 for WIDTH=32. busy is high for WIDTH+1 cycles.
- Arithmetic results:
  - Multiply: lo = product[WIDTH-1:0], hi = product[2*WIDTH-1:WIDTH].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (signed or unsigned): lo = all ones, hi = op_a unchanged. Still takes full latency.
- Signed -2^31 / -1: lo = 0x80000000, hi = 0. No trap.
- op_valid while busy=1: ignored. Operation is not queued, no state change.
- abort:
  - Applies in CALC or FIX. Return to IDLE next edge, busy=0, done stays 0, hi/lo unchanged.
  - abort in IDLE: no effect.
  - abort together with op_valid in IDLE: op dropped.
- hi/lo change only on the FIX exit edge, on MTHI/MTLO, or on reset. Reads while busy return the old values; the core must stall MFHI/MFLO on busy.

Decomposition:
- Shared constants (the core's constants header): MD_OP_* encodings, 3 bits:
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
- Shared constants also hold the state encodings MD_IDLE/MD_CALC/MD_FIX.
- The decoder maps FUNC_MULT/MULTU/DIV/DIVU/MTHI/MTLO to these codes.
- One sub-module is natural: mips_muldiv_step, a combinational single-iteration datapath. It performs the shift-add or shift-subtract given accumulator, operand and mode, so CALC is a register plus this step.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> after 33 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse, busy drops.
- MULTU a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Back-to-back and overlap:
  - MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi/lo updated one edge after each, busy never set.
  - A second MULT issued at cycle 5 of an in-flight op -> ignored; only the first result lands.
- Cancellation:
  - abort at cycle 10 of a DIV with hi=0xAAAA0000, lo=0x5555FFFF -> busy=0 next cycle, no done, hi/lo unchanged.
  - reset mid-MULT -> hi=lo=0, busy=0.
